img_axis_streamer: RTL and testbench
====================================

Name: img_axis_streamer

Overview:
- Sits between the APB register file and class_top, in the image-glue stage.
- On a start command, snapshots the 1024-bit image (32 × 32-bit APB words, i.e. 8 lines × 128 bits) into a local buffer.
- Streams the buffer to class_top as an AXI4-Stream packet: word 0 first, TLAST on the final word.
- Signals completion with a single-cycle done pulse, so APB image writes during streaming cannot corrupt the transfer in flight.

Parameters:
- DATA_W, 32: stream beat width in bits; must divide IMG_BITS.
- IMG_BITS, 1024: image size in bits.
- BEATS, IMG_BITS/DATA_W (32): beats per packet; derived, do not override.

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  start command, one-cycle pulse from an IMG_CMD write of 1
- i_img_data  in  IMG_BITS  packed APB image words; word n = bits [32n+31:32n]
- o_tdata  out  DATA_W  stream data
- o_tvalid  out  1  stream valid
- i_tready  in  1  stream ready from class_top
- o_tlast  out  1  high on the final beat
- o_busy  out  1  high while a packet is pending or in flight
- o_done_pulse  out  1  one cycle, after the last beat is accepted
- o_start_drop  out  1  one cycle, when a start is ignored because the block is busy

Behaviour:
- Reset (async, i_rst=1):
  - State goes to IDLE; beat counter = 0.
  - o_tvalid, o_tlast, o_busy, o_done_pulse, o_start_drop = 0.
  - o_tdata = 0; buffer contents don't-care.
  - Deassertion is synchronous to i_clk via a 2-flop release.
- States: IDLE, STREAM.
- IDLE:
  - i_start=1 at edge k: capture i_img_data into the buffer, clear the counter, go to STREAM.
  - After edge k: o_tvalid=1, o_busy=1, o_tdata = word 0.
  - Latency from start to first valid beat is 1 cycle.
- STREAM:
  - A handshake is o_tvalid & i_tready at a rising edge; each handshake increments the counter.
  - o_tdata = buffer word [counter].
  - o_tlast = (counter == BEATS-1) & o_tvalid.
  - Without a handshake, o_tdata, o_tlast and o_tvalid hold stable (AXI rule). o_tvalid never drops mid-packet.
- Last beat: a handshake with counter == BEATS-1 does all of the following at the same edge:
  - go to IDLE;
  - o_tvalid=0, o_busy=0;
  - o_done_pulse=1 for exactly the next cycle;
  - counter wraps to 0.
- Throughput: with i_tready held high, BEATS beats in BEATS consecutive cycles. Done pulse appears at cycle start+BEATS+1.
- Start while busy:
  - i_start in STREAM, including the last-beat cycle, is ignored and o_start_drop pulses the next cycle.
  - A start in the cycle o_done_pulse is high is accepted (state is IDLE).
- The buffer is written only on an accepted start. i_img_data changes while busy have no effect on the packet.
- No combinational path from i_tready to any output; all outputs are registered.
- Counter width is clog2(BEATS); no overflow is possible because wrap is forced at BEATS-1.
- Reset mid-packet: the packet is abandoned with no TLAST and no done pulse. The downstream consumer is reset on the same net.

Test Plan:
- Load words n = 32'hA5000000+n, pulse i_start, hold i_tready=1 -> 32 consecutive beats with tdata A5000000..A500001F, tlast only on beat 31, o_done_pulse exactly 1 cycle after beat 31, o_busy low the same cycle.
- Same image, i_tready toggling 1,0,0,1 pattern -> no beat lost or duplicated; tdata/tlast stable during every stalled cycle; done pulse after the 32nd handshake.
- Pulse i_start again at beat 10 and at the final handshake cycle -> both ignored, o_start_drop pulses twice, packet content unchanged, single done pulse.
- Overwrite all i_img_data to 32'hFFFFFFFF at beat 5 -> streamed beats 5..31 still the original values. A new start after done streams FFFFFFFF.
- Assert i_rst asynchronously at beat 17 -> o_tvalid/o_busy/o_tlast drop immediately, no done pulse. A start after release streams a fresh full 32-beat packet from word 0.
- Start in the cycle o_done_pulse is high -> accepted, o_tvalid rises the next cycle, no o_start_drop.

Source files
------------

// File: rtl/img_axis_streamer.sv
// img_axis_streamer: snapshots a packed image on a start command and streams it
// as a single AXI4-Stream packet, word 0 first, TLAST on the final word.
//
// Ports:
//   i_clk         clock, all logic on rising edge
//   i_rst         asynchronous active-high reset (released synchronously)
//   i_start       one-cycle start command
//   i_img_data    packed image, word n = bits [DATA_W*n +: DATA_W]
//   o_tdata       stream data
//   o_tvalid      stream valid
//   i_tready      stream ready
//   o_tlast       high on the final beat
//   o_busy        high while a packet is in flight
//   o_done_pulse  one cycle after the last beat is accepted
//   o_start_drop  one cycle when a start arrives while busy
module img_axis_streamer #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IMG_BITS = 1024,
  parameter int unsigned BEATS    = IMG_BITS / DATA_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [IMG_BITS-1:0] i_img_data,
  output logic [DATA_W-1:0]   o_tdata,
  output logic                o_tvalid,
  input  logic                i_tready,
  output logic                o_tlast,
  output logic                o_busy,
  output logic                o_done_pulse,
  output logic                o_start_drop
);

  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  // Reset asserts asynchronously, releases after two clock edges.
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rst_sync_q <= '1;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst_int = rst_sync_q[1];

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_nxt;
  logic [DATA_W-1:0]  img_buf_q [BEATS];
  logic [DATA_W-1:0]  img_buf_d [BEATS];
  logic [DATA_W-1:0]  tdata_q, tdata_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               drop_q, drop_d;
  logic               hs;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    img_buf_d = img_buf_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    drop_d    = 1'b0;
    hs        = tvalid_q & i_tready;
    cnt_nxt   = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          for (int unsigned i = 0; i < BEATS; i++) begin
            img_buf_d[i] = i_img_data[i*DATA_W +: DATA_W];
          end
          cnt_d    = '0;
          // Outputs are registered, so word 0 is loaded straight from the input.
          tdata_d  = i_img_data[DATA_W-1:0];
          tvalid_d = 1'b1;
          tlast_d  = (BEATS == 1);
          busy_d   = 1'b1;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (i_start) drop_d = 1'b1;
        if (hs) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d    = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            // Pre-fetch the next word so o_tdata stays a flop output.
            cnt_d   = cnt_nxt;
            tdata_d = img_buf_q[cnt_nxt];
            tlast_d = (cnt_nxt == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge rst_int) begin
    if (rst_int) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset term.
  always_ff @(posedge i_clk) begin
    img_buf_q <= img_buf_d;
  end

  assign o_tdata      = tdata_q;
  assign o_tvalid     = tvalid_q;
  assign o_tlast      = tlast_q;
  assign o_busy       = busy_q;
  assign o_done_pulse = done_q;
  assign o_start_drop = drop_q;

endmodule

// File: tb/tb_img_axis_streamer.sv
module tb_img_axis_streamer;

  logic          i_clk;
  logic          i_rst;
  logic          i_start;
  logic [1023:0] i_img_data;
  logic [31:0]   o_tdata;
  logic          o_tvalid;
  logic          i_tready;
  logic          o_tlast;
  logic          o_busy;
  logic          o_done_pulse;
  logic          o_start_drop;

  img_axis_streamer #(.DATA_W(32), .IMG_BITS(1024)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_img_data   (i_img_data),
    .o_tdata      (o_tdata),
    .o_tvalid     (o_tvalid),
    .i_tready     (i_tready),
    .o_tlast      (o_tlast),
    .o_busy       (o_busy),
    .o_done_pulse (o_done_pulse),
    .o_start_drop (o_start_drop)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    failures = 0;
  logic  exp_valid = 1'b0;
  logic  exp_done = 1'b0;
  logic  exp_drop = 1'b0;
  int    beats_seen = 0;
  int    drops_seen = 0;
  int    dones_seen = 0;
  logic [1023:0] img_a;
  logic [1023:0] img_f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, predict the effect of the next
  // rising edge, then check outputs at the following falling edge.
  task automatic tick(input logic st, input logic rdy);
    logic  nv, nd, ndr;
    beat_t b;
    i_start  = st;
    i_tready = rdy;
    nv  = exp_valid;
    nd  = 1'b0;
    ndr = 1'b0;
    if (exp_valid) begin
      if (st) ndr = 1'b1;
      if (rdy) begin
        b = sb.pop_front();
        beats_seen++;
        if (b.last) begin
          nv = 1'b0;
          nd = 1'b1;
        end
      end
    end else if (st) begin
      for (int unsigned n = 0; n < 32; n++) begin
        b.d    = i_img_data[32*n +: 32];
        b.last = (n == 31);
        sb.push_back(b);
      end
      beats_seen = 0;
      nv = 1'b1;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_start   = 1'b0;
    exp_valid = nv;
    exp_done  = nd;
    exp_drop  = ndr;
    drops_seen += int'(o_start_drop);
    dones_seen += int'(o_done_pulse);
    chk("tvalid", 32'(o_tvalid), 32'(exp_valid));
    chk("busy", 32'(o_busy), 32'(exp_valid));
    chk("done_pulse", 32'(o_done_pulse), 32'(exp_done));
    chk("start_drop", 32'(o_start_drop), 32'(exp_drop));
    if (exp_valid) begin
      chk("tdata", o_tdata, sb[0].d);
      chk("tlast", 32'(o_tlast), 32'(sb[0].last));
    end else begin
      chk("tlast_idle", 32'(o_tlast), 32'd0);
    end
  endtask

  // mode 0: ready high; 1: ready 1,0,0,1; 2: extra starts at beat 10 and on
  // the final handshake; 3: overwrite image with all-ones at beat 5.
  task automatic run_until_idle(input int mode);
    int   guard;
    logic rdy, st;
    logic injected;
    guard = 0;
    injected = 1'b0;
    while (exp_valid && guard < 300) begin
      rdy = 1'b1;
      st  = 1'b0;
      if (mode == 1) rdy = (guard % 4 == 0) || (guard % 4 == 3);
      if (mode == 2) begin
        if (beats_seen == 10 && !injected) begin
          st = 1'b1;
          injected = 1'b1;
        end
        if (sb.size() == 1) st = 1'b1;
      end
      if (mode == 3 && beats_seen == 5) i_img_data = img_f;
      tick(st, rdy);
      guard++;
    end
    if (guard >= 300) chk("timeout", 32'd1, 32'd0);
  endtask

  initial begin
    for (int n = 0; n < 32; n++) begin
      img_a[32*n +: 32] = 32'hA500_0000 + 32'(n);
    end
    img_f = '1;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_tready = 1'b0;
    i_img_data = img_a;

    // Reset state
    #3;
    chk("rst_tvalid", 32'(o_tvalid), 32'd0);
    chk("rst_tlast", 32'(o_tlast), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done_pulse), 32'd0);
    chk("rst_drop", 32'(o_start_drop), 32'd0);
    chk("rst_tdata", o_tdata, 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (3) tick(1'b0, 1'b1);

    // Full-rate packet, then done must last a single cycle
    tick(1'b1, 1'b1);
    chk("first_beat_latency", 32'(o_tvalid), 32'd1);
    run_until_idle(0);
    tick(1'b0, 1'b1);

    // Back-pressure pattern
    dones_seen = 0;
    tick(1'b1, 1'b0);
    run_until_idle(1);
    chk("stall_done_count", 32'(dones_seen), 32'd1);
    tick(1'b0, 1'b0);

    // Starts while busy are dropped
    drops_seen = 0;
    dones_seen = 0;
    tick(1'b1, 1'b1);
    run_until_idle(2);
    tick(1'b0, 1'b1);
    chk("drop_count", 32'(drops_seen), 32'd2);
    chk("drop_done_count", 32'(dones_seen), 32'd1);

    // Image overwritten mid-packet; restart in the done cycle streams all-ones
    tick(1'b1, 1'b1);
    run_until_idle(3);
    chk("done_cycle_start_done", 32'(o_done_pulse), 32'd1);
    tick(1'b1, 1'b1);
    chk("done_cycle_start_tdata", o_tdata, 32'hFFFF_FFFF);
    run_until_idle(0);
    tick(1'b0, 1'b1);

    // Asynchronous reset mid-packet
    i_img_data = img_a;
    tick(1'b1, 1'b1);
    while (beats_seen < 17) tick(1'b0, 1'b1);
    #2 i_rst = 1'b1;
    #1;
    chk("async_rst_tvalid", 32'(o_tvalid), 32'd0);
    chk("async_rst_busy", 32'(o_busy), 32'd0);
    chk("async_rst_tlast", 32'(o_tlast), 32'd0);
    sb.delete();
    exp_valid = 1'b0;
    dones_seen = 0;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    i_rst = 1'b0;
    repeat (3) tick(1'b0, 1'b1);
    chk("rst_no_done", 32'(dones_seen), 32'd0);
    tick(1'b1, 1'b1);
    chk("post_rst_word0", o_tdata, 32'hA500_0000);
    run_until_idle(0);
    tick(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
